// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter for the data port of a
//               single-cycle MIPS core. Decodes a 4-word window at
//               BASE_ADDR, queues bytes in a small TX FIFO and serialises them
//               LSB first on tx_o. Register reads are combinational so the
//               core gets readdata within the same cycle.
//
//               Register map (offset = addr[3:2]):
//                 0 TXDATA (W)  push wdata[7:0], reads 0
//                 1 STATUS (RW) [0] full [1] empty [2] busy [3] overflow
//                               [7:4] count [8] parity build flag;
//                               writing wdata[3]=1 clears overflow
//                 2 CTRL   (RW) [0] enable
//                 3 reserved    reads 0, writes ignored
//
//               Optional feature macro: UART_PARITY_EN adds an even parity
//               bit between the data bits and the stop bit.
//
// Ports       : clk_i      system clock, rising edge
//               rst_ni     asynchronous active-low reset
//               addr_i     data address from the core
//               wdata_i    store data from the core
//               memwrite_i store strobe from the core
//               sel_o      address falls inside the register window
//               rdata_o    combinational register read data
//               tx_o       serial output, idle high
//               irq_o      FIFO empty and transmitter idle
//
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        memwrite_i,
  output logic        sel_o,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
  localparam logic [1:0]    OFF_TXDATA = 2'd0;
  localparam logic [1:0]    OFF_STATUS = 2'd1;
  localparam logic [1:0]    OFF_CTRL   = 2'd2;

`ifdef UART_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_e;

  state_e          state_q;
  logic            tx_q;
  logic [7:0]      shift_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
`ifdef UART_PARITY_EN
  logic            par_q;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            enable_q, enable_d;

  logic            w_wr;
  logic [1:0]      w_off;
  logic            w_empty;
  logic            w_full;
  logic            w_baud_end;
  logic            w_pop;
  logic            w_push;
  logic            w_push_ok;
  logic [7:0]      w_head;
  logic            w_busy;
  logic [3:0]      w_cnt4;
  logic            w_unused;

  assign sel_o      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off      = addr_i[3:2];
  assign w_wr       = memwrite_i & sel_o;
  assign w_empty    = (cnt_q == '0);
  assign w_full     = (cnt_q == CNT_FULL);
  assign w_baud_end = (baud_q == BAUD_LAST);
  assign w_head     = mem_q[rptr_q];
  assign w_busy     = (state_q != S_IDLE);
  assign w_cnt4     = 4'(cnt_q);
  assign w_unused   = ^{addr_i[1:0], wdata_i[31:8]};

  // Popping at the last cycle of STOP (not only in IDLE) keeps queued
  // frames back-to-back with no idle cycle between them.
  assign w_pop = enable_q & ~w_empty &
                 ((state_q == S_IDLE) | ((state_q == S_STOP) & w_baud_end));

  // A push into a full FIFO still succeeds when the head leaves this cycle.
  assign w_push    = w_wr & (w_off == OFF_TXDATA);
  assign w_push_ok = w_push & (~w_full | w_pop);

  assign cnt_d    = cnt_q + CW'(w_push_ok) - CW'(w_pop);
  assign enable_d = (w_wr && w_off == OFF_CTRL) ? wdata_i[0] : enable_q;

  always_comb begin
    ovf_d = ovf_q;
    if (w_push && !w_push_ok) begin
      ovf_d = 1'b1;
    end else if (w_wr && w_off == OFF_STATUS && wdata_i[3]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    if (sel_o) begin
      case (w_off)
        OFF_STATUS: rdata_o = {23'd0, PAR_FLAG, w_cnt4, ovf_q, w_busy, w_empty, w_full};
        OFF_CTRL:   rdata_o = {31'd0, enable_q};
        default:    rdata_o = 32'd0;
      endcase
    end
  end

  assign tx_o  = tx_q;
  assign irq_o = w_empty & ~w_busy;

  // FIFO storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      mem_q[wptr_q] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      if (w_push_ok) wptr_q <= wptr_q + AW'(1);
      if (w_pop)     rptr_q <= rptr_q + AW'(1);
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      enable_q <= enable_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      shift_q <= 8'd0;
      baud_q  <= '0;
      bit_q   <= 3'd0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (w_pop) begin
      shift_q <= w_head;
`ifdef UART_PARITY_EN
      par_q   <= ^w_head;
`endif
      baud_q  <= '0;
      state_q <= S_START;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
        end
        S_START: begin
          if (w_baud_end) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_baud_end) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_baud_end) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx. Serial output is
//               compared cycle by cycle against the ideal frame waveform
//               derived from a queue of expected bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          CPB   = 16;
  localparam int          DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int          FB    = 11;
  localparam logic [31:0] PFLAG = 32'h100;
`else
  localparam int          FB    = 10;
  localparam logic [31:0] PFLAG = 32'h0;
`endif
  localparam int          FRAME = FB * CPB;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_CT  = BASE + 32'h8;
  localparam logic [31:0] A_RS  = BASE + 32'hC;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memwrite;
  logic        sel;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  logic       tx_log   [0:2047];
  logic       busy_log [0:2047];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .memwrite_i (memwrite),
    .sel_o      (sel),
    .rdata_o    (rdata),
    .tx_o       (tx),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference STATUS word from queue occupancy and flags.
  function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit busy);
    logic [31:0] s;
    s = PFLAG | (32'(cnt) << 4);
    if (ovf)          s = s | 32'h8;
    if (busy)         s = s | 32'h4;
    if (cnt == 0)     s = s | 32'h2;
    if (cnt == DEPTH) s = s | 32'h1;
    return s;
  endfunction

  // Ideal line level at cycle i after the first start edge, frames of exp_q
  // sent back to back.
  function automatic logic exp_tx(input int i);
    int f;
    int w;
    logic [7:0] b;
    f = i / FRAME;
    if (f >= exp_q.size()) return 1'b1;
    w = (i % FRAME) / CPB;
    b = exp_q[f];
    if (w == 0) return 1'b0;
    if (w <= 8) return b[w-1];
    if (FB == 11 && w == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic int first_diff(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      if (tx_log[i] !== exp_tx(i + off)) return i;
    end
    return -1;
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr     = a;
    wdata    = d;
    memwrite = 1'b1;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    addr     = A_ST;
    wdata    = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    memwrite = 1'b0;
    #1;
    d = rdata;
  endtask

  // Record tx and busy for n cycles, starting at a rising edge. When
  // dis_at >= 0 a CTRL=0 write is slipped in after sample dis_at.
  task automatic capture(input int n, input int dis_at);
    for (int i = 0; i < n; i++) begin
      #1;
      tx_log[i]   = tx;
      busy_log[i] = rdata[2];
      if (i == dis_at + 1) begin
        memwrite = 1'b0;
        addr     = A_ST;
        wdata    = 32'd0;
      end
      if (i == dis_at) begin
        addr     = A_CT;
        wdata    = 32'd0;
        memwrite = 1'b1;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(0, 0, 0) || irq !== 1'b1 || tx !== 1'b1 || sel !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: status=%h irq=%b tx=%b sel=%b, expected status=%h irq=1 tx=1 sel=1",
               d, irq, tx, sel, status_word(0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    bus_read(A_CT, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h, expected 0", d);
    end
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(0, 0, 0) || tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_status: status=%h tx=%b, expected %h tx=1", d, tx, status_word(0, 0, 0));
    end
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    logic [31:0] d;
    int          diff;
    int          nb;
    @(negedge clk);
    bus_write(A_CT, 32'd1);
    bus_write(A_TX, {24'd0, b});
    n_checks++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_latency: tx=%b right after write edge, expected 1", tx);
    end
    exp_q.delete();
    exp_q.push_back(b);
    @(posedge clk);
    capture(FRAME + CPB, -1);
    diff = first_diff(FRAME + CPB, 0);
    n_checks++;
    if (diff !== -1) begin
      n_fail++;
      $display("FAIL frame_%h: tx=%b at cycle %0d, expected %b", b, tx_log[diff], diff, exp_tx(diff));
    end
    nb = 0;
    for (int i = 0; i < FRAME; i++) if (busy_log[i] !== 1'b1) nb++;
    n_checks++;
    if (nb !== 0 || busy_log[FRAME] !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_busy: %0d non-busy cycles in frame, busy after=%b, expected 0 and 0",
               nb, busy_log[FRAME]);
    end
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(0, 0, 0) || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_done: status=%h irq=%b, expected %h irq=1", d, irq, status_word(0, 0, 0));
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int          diff;
    @(negedge clk);
    bus_write(A_CT, 32'd0);
    for (int k = 1; k <= 5; k++) bus_write(A_TX, 32'(k));
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(4, 1, 0)) begin
      n_fail++;
      $display("FAIL ovf_set: status=%h, expected %h", d, status_word(4, 1, 0));
    end
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(4, 0, 0)) begin
      n_fail++;
      $display("FAIL ovf_clear: status=%h, expected %h", d, status_word(4, 0, 0));
    end
    exp_q.delete();
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    bus_write(A_CT, 32'd1);
    @(posedge clk);
    capture(4 * FRAME, -1);
    diff = first_diff(4 * FRAME, 0);
    n_checks++;
    if (diff !== -1) begin
      n_fail++;
      $display("FAIL b2b_stream: tx=%b at cycle %0d, expected %b", tx_log[diff], diff, exp_tx(diff));
    end
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(0, 0, 0)) begin
      n_fail++;
      $display("FAIL b2b_done: status=%h, expected %h", d, status_word(0, 0, 0));
    end
  endtask

  task automatic test_push_during_pop();
    logic [31:0] d;
    logic [7:0]  b;
    int          diff;
    @(negedge clk);
    bus_write(A_CT, 32'd0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      bus_write(A_TX, {24'd0, b});
    end
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(4, 0, 0)) begin
      n_fail++;
      $display("FAIL pp_full: status=%h, expected %h", d, status_word(4, 0, 0));
    end
    b = 8'($urandom);
    exp_q.push_back(b);
    bus_write(A_CT, 32'd1);
    bus_write(A_TX, {24'd0, b});
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(4, 0, 1)) begin
      n_fail++;
      $display("FAIL pp_accept: status=%h, expected %h", d, status_word(4, 0, 1));
    end
    @(posedge clk);
    capture(5 * FRAME - 1, -1);
    diff = first_diff(5 * FRAME - 1, 1);
    n_checks++;
    if (diff !== -1) begin
      n_fail++;
      $display("FAIL pp_stream: tx=%b at cycle %0d, expected %b", tx_log[diff], diff + 1, exp_tx(diff + 1));
    end
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(0, 0, 0)) begin
      n_fail++;
      $display("FAIL pp_done: status=%h, expected %h", d, status_word(0, 0, 0));
    end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    @(negedge clk);
    bus_write(A_CT, 32'd0);
    bus_write(A_TX, 32'h77);
    addr     = BASE + 32'h10;
    wdata    = 32'hFF;
    memwrite = 1'b1;
    #1;
    n_checks++;
    if (sel !== 1'b0 || rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL dec_outside: sel=%b rdata=%h, expected sel=0 rdata=0", sel, rdata);
    end
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    bus_write(A_RS, 32'hFFFF_FFFF);
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(1, 0, 0) || sel !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_count: status=%h sel=%b, expected %h sel=1", d, sel, status_word(1, 0, 0));
    end
    bus_read(A_RS, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL dec_reserved: got %h, expected 0", d);
    end
    bus_write(A_CT, 32'd1);
    bus_read(A_CT, d);
    n_checks++;
    if (d !== 32'd1) begin
      n_fail++;
      $display("FAIL dec_ctrl: got %h, expected 1", d);
    end
    bus_read(A_TX, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL dec_txdata: got %h, expected 0", d);
    end
    repeat (FRAME + 4) @(posedge clk);
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(0, 0, 0)) begin
      n_fail++;
      $display("FAIL dec_drain: status=%h, expected %h", d, status_word(0, 0, 0));
    end
  endtask

  task automatic test_disable_midframe();
    logic [31:0] d;
    logic [7:0]  b0, b1;
    int          diff;
    @(negedge clk);
    bus_write(A_CT, 32'd0);
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    bus_write(A_TX, {24'd0, b0});
    bus_write(A_TX, {24'd0, b1});
    exp_q.delete();
    exp_q.push_back(b0);
    bus_write(A_CT, 32'd1);
    @(posedge clk);
    capture(FRAME + 3 * CPB, 20);
    diff = first_diff(FRAME + 3 * CPB, 0);
    n_checks++;
    if (diff !== -1) begin
      n_fail++;
      $display("FAIL dis_stream: tx=%b at cycle %0d, expected %b", tx_log[diff], diff, exp_tx(diff));
    end
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(1, 0, 0) || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_status: status=%h irq=%b, expected %h irq=0", d, irq, status_word(1, 0, 0));
    end
    bus_write(A_CT, 32'd1);
    repeat (FRAME + 2) @(posedge clk);
    bus_read(A_ST, d);
    n_checks++;
    if (d !== status_word(0, 0, 0)) begin
      n_fail++;
      $display("FAIL dis_drain: status=%h, expected %h", d, status_word(0, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  b;
    int          n;
    int          diff;
    for (int it = 0; it < 3; it++) begin
      @(negedge clk);
      bus_write(A_CT, 32'd0);
      n = int'($urandom_range(1, 4));
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_write(A_TX, {24'd0, b});
      end
      bus_write(A_CT, 32'd1);
      @(posedge clk);
      capture(n * FRAME, -1);
      diff = first_diff(n * FRAME, 0);
      n_checks++;
      if (diff !== -1) begin
        n_fail++;
        $display("FAIL rnd_stream[%0d]: tx=%b at cycle %0d, expected %b",
                 it, tx_log[diff], diff, exp_tx(diff));
      end
      bus_read(A_ST, d);
      n_checks++;
      if (d !== status_word(0, 0, 0)) begin
        n_fail++;
        $display("FAIL rnd_done[%0d]: status=%h, expected %h", it, d, status_word(0, 0, 0));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int          lows;
    @(negedge clk);
    bus_write(A_CT, 32'd0);
    bus_write(A_TX, 32'h3C);
    bus_write(A_TX, {24'd0, 8'($urandom)});
    bus_write(A_TX, {24'd0, 8'($urandom)});
    bus_write(A_CT, 32'd1);
    @(posedge clk);
    repeat (50) @(posedge clk);
    #2;
    n_checks++;
    if (rdata[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_busy: busy=%b, expected 1", rdata[2]);
    end
    #1;
    rst_n = 1'b0;
    #1;
    bus_read(A_ST, d);
    n_checks++;
    if (tx !== 1'b1 || irq !== 1'b1 || d !== status_word(0, 0, 0)) begin
      n_fail++;
      $display("FAIL rst_mid: tx=%b irq=%b status=%h, expected tx=1 irq=1 status=%h",
               tx, irq, d, status_word(0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    bus_read(A_ST, d);
    n_checks++;
    if (lows !== 0 || d !== status_word(0, 0, 0)) begin
      n_fail++;
      $display("FAIL rst_after: %0d low cycles, status=%h, expected 0 and %h",
               lows, d, status_word(0, 0, 0));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    addr     = A_ST;
    wdata    = 32'd0;
    memwrite = 1'b0;
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(8'($urandom));
    test_overflow();
    test_push_during_pop();
    test_decode();
    test_disable_midframe();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
